// File: rtl/mp_add_seq.sv
// Multi-word sequential adder/subtractor: a single 16-bit adder is reused
// over NWORDS cycles, least-significant word first, with a registered carry.

module mp_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] y,
  output logic        cout
);
  assign {cout, y} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module mp_add_seq #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*NWORDS-1:0]   op_a,
  input  logic [16*NWORDS-1:0]   op_b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NWORDS-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow
);
  localparam int W  = 16 * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            sub_reg;
  logic [IW-1:0]   idx;
  logic            carry;

  logic [15:0]     a_word;
  logic [15:0]     b_word;
  logic            cin;
  logic [15:0]     y;
  logic            cout;

  // Subtraction is A + ~B + 1: invert B and seed the chain with sub.
  assign a_word = a_reg[{idx, 4'b0000} +: 16];
  assign b_word = b_reg[{idx, 4'b0000} +: 16] ^ {16{sub_reg}};
  assign cin    = (idx == '0) ? sub_reg : carry;

  mp_add16 adder (
    .a    (a_word),
    .b    (b_word),
    .cin  (cin),
    .y    (y),
    .cout (cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            sub_reg <= sub;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result[{idx, 4'b0000} +: 16] <= y;
          carry <= cout;
          if (idx == LAST) begin
            carry_out <= cout;
            overflow  <= (a_word[15] == b_word[15]) && (y[15] != a_word[15]);
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
